// File: rtl/por_rst_seq.sv
// rtl/por_rst_seq.sv - POR-driven staged release of NUM_STG active-low reset domains
// Optional per-stage acknowledge with timeout: define POR_RST_SEQ_ACK_EN.
module por_rst_seq #(
  parameter int NUM_STG  = 4,
  parameter int DLY_W    = 8,
  parameter int SYNC_STG = 2,
  parameter int ACK_TO   = 16
) (
  input  logic                     osc_ck,
  input  logic                     rst,
  input  logic                     por_in,
  input  logic                     rearm,
  input  logic [NUM_STG*DLY_W-1:0] stg_dly,
  input  logic [NUM_STG-1:0]       stg_ack,
  output logic [NUM_STG-1:0]       rstb_out,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic [2:0]               stg_idx,
  output logic [NUM_STG-1:0]       ack_err
);

`ifdef POR_RST_SEQ_ACK_EN
  typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_REL, ST_WACK, ST_DONE} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_REL, ST_DONE} state_t;
`endif

  localparam int       AW       = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TO - 1);
  localparam logic [2:0]    LAST_IDX = 3'(NUM_STG - 1);

  state_t               state_q, state_d;
  logic [SYNC_STG-1:0]  sync_q;
  logic                 por_prev_q;
  logic                 por_s, por_rise;
  logic [2:0]           idx_q, idx_d;
  logic [DLY_W-1:0]     cnt_q, cnt_d;
  logic [NUM_STG-1:0]   rstb_q, rstb_d;
  logic [NUM_STG-1:0]   sel_mask;
  logic [DLY_W-1:0]     dly_next;
  logic                 adv;

`ifdef POR_RST_SEQ_ACK_EN
  logic [AW-1:0]        acnt_q, acnt_d;
  logic [NUM_STG-1:0]   err_q, err_d;
  logic                 ack_sel;
`else
  logic                 unused_ack;
  logic [AW-1:0]        unused_to;
  assign unused_ack = ^stg_ack;
  assign unused_to  = ACK_LAST;
`endif

  assign por_s    = sync_q[SYNC_STG-1];
  assign por_rise = por_s & ~por_prev_q;

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      por_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STG-2:0], por_in};
      por_prev_q <= por_s;
    end
  end

  // Stage decode by loop so a 3-bit index never over-indexes a narrower vector.
  always_comb begin
    sel_mask = '0;
    dly_next = '0;
    for (int i = 0; i < NUM_STG; i++) begin
      if (idx_q == 3'(i)) sel_mask[i] = 1'b1;
      if (idx_q + 3'd1 == 3'(i)) dly_next = stg_dly[i*DLY_W +: DLY_W];
    end
  end

`ifdef POR_RST_SEQ_ACK_EN
  assign ack_sel = |(stg_ack & sel_mask);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rstb_d  = rstb_q;
    adv     = 1'b0;
`ifdef POR_RST_SEQ_ACK_EN
    acnt_d  = acnt_q;
    err_d   = err_q;
`endif
    if (state_q != ST_IDLE && por_rise) begin
      state_d = ST_HOLD;
      rstb_d  = '0;
`ifdef POR_RST_SEQ_ACK_EN
      err_d   = '0;
`endif
    end else if (state_q != ST_IDLE && rearm) begin
      state_d = ST_HOLD;
      rstb_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (por_s) state_d = ST_HOLD;
        ST_HOLD: begin
          if (!por_s) begin
            idx_d   = 3'd0;
            cnt_d   = stg_dly[DLY_W-1:0];
            state_d = ST_REL;
          end
        end
        ST_REL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DLY_W'(1);
          end else begin
            rstb_d = rstb_q | sel_mask;
`ifdef POR_RST_SEQ_ACK_EN
            acnt_d  = '0;
            state_d = ST_WACK;
`else
            adv = 1'b1;
`endif
          end
        end
`ifdef POR_RST_SEQ_ACK_EN
        ST_WACK: begin
          if (ack_sel) begin
            adv = 1'b1;
          end else if (acnt_q == ACK_LAST) begin
            adv   = 1'b1;
            err_d = err_q | sel_mask;
          end else begin
            acnt_d = acnt_q + AW'(1);
          end
        end
`endif
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
      if (adv) begin
        if (idx_q < LAST_IDX) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = dly_next;
          state_d = ST_REL;
        end else begin
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      rstb_q  <= '0;
`ifdef POR_RST_SEQ_ACK_EN
      acnt_q  <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rstb_q  <= rstb_d;
`ifdef POR_RST_SEQ_ACK_EN
      acnt_q  <= acnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign rstb_out = rstb_q;
  assign seq_done = (state_q == ST_DONE);
  assign stg_idx  = idx_q;
`ifdef POR_RST_SEQ_ACK_EN
  assign seq_busy = (state_q == ST_HOLD) || (state_q == ST_REL) || (state_q == ST_WACK);
  assign ack_err  = err_q;
`else
  assign seq_busy = (state_q == ST_HOLD) || (state_q == ST_REL);
  assign ack_err  = '0;
`endif

endmodule

// File: tb/tb_por_rst_seq.sv
// tb/tb_por_rst_seq.sv - directed self-checking bench for por_rst_seq
module tb_por_rst_seq;
  localparam int NUM_STG = 4;
  localparam int DLY_W   = 8;

`ifdef POR_RST_SEQ_ACK_EN
  localparam int R0 = 6, R1 = 8, R2 = 15, R3 = 18, RD = 19;
  localparam int Z0 = 2, Z1 = 4, Z2 = 6, Z3 = 8, ZD = 9;
  localparam logic [3:0] EXP_ERR = 4'b0010;
`else
  localparam int R0 = 6, R1 = 7, R2 = 13, R3 = 15, RD = 15;
  localparam int Z0 = 2, Z1 = 3, Z2 = 4, Z3 = 5, ZD = 5;
  localparam logic [3:0] EXP_ERR = 4'b0000;
`endif

  logic                     osc_ck = 1'b0;
  logic                     rst, por_in, rearm;
  logic [NUM_STG*DLY_W-1:0] stg_dly;
  logic [NUM_STG-1:0]       stg_ack, rstb_out, ack_err;
  logic                     seq_busy, seq_done;
  logic [2:0]               stg_idx;
  int checks = 0;
  int errors = 0;

  por_rst_seq #(.NUM_STG(4), .DLY_W(8), .SYNC_STG(2), .ACK_TO(16)) dut (
    .osc_ck(osc_ck), .rst(rst), .por_in(por_in), .rearm(rearm),
    .stg_dly(stg_dly), .stg_ack(stg_ack), .rstb_out(rstb_out),
    .seq_busy(seq_busy), .seq_done(seq_done), .stg_idx(stg_idx), .ack_err(ack_err)
  );

  always #5 osc_ck = ~osc_ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rel_pat(input int m, input int a, input int b, input int c, input int d);
    return {m >= d, m >= c, m >= b, m >= a};
  endfunction

  task automatic tick();
    @(posedge osc_ck);
    #1;
  endtask

  task automatic run_release(input string tag);
    for (int m = 0; m <= 20; m++) begin
      tick();
      chk({tag, "_rstb"}, rstb_out, rel_pat(m, R0, R1, R2, R3));
      chk({tag, "_done"}, seq_done, (m >= RD) ? 1 : 0);
    end
    chk({tag, "_busy"}, seq_busy, 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (seq_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, seq_done, 1);
  endtask

  task automatic wait_idx2(input string tag);
    int n = 0;
    while (stg_idx !== 3'd2 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, stg_idx, 2);
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    por_in  = 1'b0;
    rearm   = 1'b0;
    stg_ack = '1;
    stg_dly = {8'd1, 8'd5, 8'd0, 8'd3};
    tick();
    tick();
    chk("rst_rstb", rstb_out, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_idx", stg_idx, 0);
    chk("rst_err", ack_err, 0);

    rst = 1'b0;
    repeat (3) tick();
    pulse_rearm();
    tick();
    chk("idle_rearm_busy", seq_busy, 0);
    chk("idle_rearm_rstb", rstb_out, 0);

    por_in = 1'b1;
    repeat (20) tick();
    chk("hold_busy", seq_busy, 1);
    chk("hold_rstb", rstb_out, 0);
    por_in = 1'b0;
    run_release("basic");
    chk("basic_err", ack_err, 0);

    pulse_rearm();
    chk("rearm_rstb", rstb_out, 0);
    chk("rearm_done", seq_done, 0);
    chk("rearm_busy", seq_busy, 1);
    for (int m = 1; m <= 5; m++) begin
      tick();
      chk("rearm_rstb0", rstb_out[0], (m >= 5) ? 1 : 0);
    end
    wait_done("rearm_complete");

    stg_dly = '0;
    pulse_rearm();
    for (int m = 1; m <= 10; m++) begin
      tick();
      chk("zero_rstb", rstb_out, rel_pat(m, Z0, Z1, Z2, Z3));
      chk("zero_done", seq_done, (m >= ZD) ? 1 : 0);
    end
    chk("zero_err", ack_err, 0);

    stg_dly = {8'd1, 8'd5, 8'd0, 8'd3};
`ifdef POR_RST_SEQ_ACK_EN
    stg_ack = 4'b1101;
    pulse_rearm();
    for (int m = 1; m <= 30; m++) begin
      tick();
      chk("to_rstb", rstb_out, rel_pat(m, 5, 7, 29, 32));
      chk("to_err", ack_err, (m >= 23) ? 4'b0010 : 4'b0000);
    end
    wait_done("to_complete");
    chk("to_err_final", ack_err, 4'b0010);
    stg_ack = '1;
`endif

    pulse_rearm();
    chk("rearm_keeps_err", ack_err, EXP_ERR);
    wait_idx2("por_reach_idx2");
    por_in = 1'b1;
    tick();
    tick();
    chk("por_sync_rstb", rstb_out, 4'b0011);
    tick();
    chk("por_clear_rstb", rstb_out, 0);
    chk("por_clear_err", ack_err, 0);
    chk("por_clear_busy", seq_busy, 1);
    repeat (5) tick();
    chk("por_hold_busy", seq_busy, 1);
    chk("por_hold_rstb", rstb_out, 0);
    chk("por_hold_done", seq_done, 0);
    por_in = 1'b0;
    run_release("repor");

    pulse_rearm();
    wait_idx2("arst_reach_idx2");
    #3;
    rst = 1'b1;
    #1;
    chk("arst_rstb", rstb_out, 0);
    chk("arst_busy", seq_busy, 0);
    chk("arst_idx", stg_idx, 0);
    chk("arst_done", seq_done, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("arst_idle_busy", seq_busy, 0);
    chk("arst_idle_rstb", rstb_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/por_rst_seq.md
Name: por_rst_seq

Overview:
- Sits directly downstream of the POR one-shot and consumes its unbuffered POR pulse on por_in.
- Holds every downstream reset domain asserted while POR is active.
- After POR ends, releases the domains one at a time, in index order, with a programmable per-stage delay.
- Optionally waits for a per-stage acknowledge, with a timeout, before releasing the next domain.

Parameters:
- NUM_STG, 4: number of sequenced reset domains (2..8).
- DLY_W, 8: width of each per-stage delay field.
- SYNC_STG, 2: synchronizer depth on por_in (2..3).
- ACK_TO, 16: cycles to wait for an acknowledge before a stage times out.

Ports:
- osc_ck  in  1  sequencer clock.
- rst  in  1  asynchronous, active-high reset.
- por_in  in  1  POR pulse from the one-shot; asynchronous to osc_ck.
- rearm  in  1  synchronous single-cycle request to re-run the sequence.
- stg_dly  in  NUM_STG*DLY_W  per-stage release delays; stage i uses bits [i*DLY_W +: DLY_W].
- stg_ack  in  NUM_STG  per-stage acknowledges; already synchronous to osc_ck.
- rstb_out  out  NUM_STG  active-low domain resets.
- seq_busy  out  1  high while a sequence is in HOLD, REL or WACK.
- seq_done  out  1  high once all stages are released.
- stg_idx  out  3  stage currently being processed.
- ack_err  out  NUM_STG  sticky per-stage timeout flags.

Behaviour:
- Reset (rst high, asynchronous, any time):
  - rstb_out=0, seq_busy=0, seq_done=0, stg_idx=0, ack_err=0.
  - Synchronizer flops cleared to 0; FSM returns to IDLE.
  - Asserting rst mid-sequence aborts it immediately.
- Synchronizer: por_in passes through SYNC_STG flops to give por_s. An input change before edge k appears on por_s after edge k+SYNC_STG-1.
- FSM states: IDLE, HOLD, REL, WACK, DONE. stg_idx and a DLY_W-bit down-counter are registered.
- IDLE:
  - rstb_out=0.
  - On por_s=1, go to HOLD.
  - rearm has no effect in IDLE.
- HOLD:
  - rstb_out=0, seq_busy=1.
  - On the first edge that samples por_s=0: stg_idx=0, counter loads stg_dly[0], go to REL.
- REL:
  - If counter≠0, decrement it.
  - If counter=0, set rstb_out[stg_idx] to 1 on this edge and go to WACK.
  - stg_dly is sampled only at REL entry.
  - A delay of D releases the stage D+1 edges after REL entry; D=0 releases on the next edge.
- WACK:
  - Counts cycles from 0.
  - Advances when stg_ack[stg_idx]=1.
  - Also advances when the count reaches ACK_TO-1 without an acknowledge; in that case ack_err[stg_idx] is set.
  - Advancing means: if stg_idx<NUM_STG-1, increment stg_idx, load the next delay and go to REL; otherwise go to DONE.
  - An acknowledge in the same cycle as timeout counts as acknowledged: no error is set.
- DONE: rstb_out all 1, seq_done=1, seq_busy=0.
- Restart on a POR rising edge: if por_s goes 0→1 in any non-IDLE state:
  - all rstb_out clear next edge; seq_done=0; ack_err cleared; go to HOLD.
- Restart on rearm: if rearm=1 in HOLD, REL, WACK or DONE:
  - all rstb_out clear next edge; seq_done=0; ack_err kept; go to HOLD.
  - If por_s is already 0, the sequence restarts from stage 0 on the following edge.
- A simultaneous POR rising edge and rearm follow the POR rule (ack_err cleared).
- Only the one stage selected by stg_idx can change rstb_out in a given cycle. Released stages stay released until rst, a POR rising edge or rearm.

Optional Feature:
- Macro: POR_RST_SEQ_ACK_EN.
- Defined: WACK state, stg_ack handling and ack_err behave as described above.
- Undefined:
  - WACK is removed; REL advances to the next stage, or to DONE, on the same edge that releases the current stage.
  - stg_ack is ignored and ack_err is tied to 0.
  - Release spacing between stages is then exactly stg_dly[i]+1 cycles.

Test Plan:
- Basic release (NUM_STG=4, SYNC_STG=2, stg_dly={3,0,5,1}, stg_ack tied high, feature on):
  - por_in pulsed high for 20 cycles, then falls before edge k → rstb_out[0] rises at edge k+6.
  - Each later stage releases dly+2 cycles after the previous one (acknowledge cycle included).
  - seq_done=1 once rstb_out=4'hF.
- Ack timeout (stg_ack[1]=0, ACK_TO=16) → ack_err=4'b0010; stage 2 begins REL 16 cycles after rstb_out[1] rises; the sequence still completes.
- POR during release: por_in rises while stg_idx=2 → rstb_out=0 within SYNC_STG+1 edges; ack_err=0; FSM in HOLD until por_in falls, then re-sequences from stage 0.
- rearm pulse in DONE with por_in=0 → rstb_out=0 next edge; rstb_out[0] rises again stg_dly[0]+2 edges after the rearm edge.
- Async rst asserted mid-REL, between clock edges → all outputs 0 immediately; after rst releases, FSM stays in IDLE with por_in low.
- Feature off: stg_dly={0,0,0,0} → rstb_out goes 0001, 0011, 0111, 1111 on consecutive edges; ack_err constant 0.
